operand_debounce: RTL and testbench
===================================

Name: operand_debounce

Overview:
- Front-end input stage feeding the 4-bit lookahead adder and the seven-segment display top level.
- Synchronises and debounces the two 4-bit slide-switch operands and a "load" pushbutton.
- Presents clean, registered operands A/B plus a one-cycle load strobe, so the adder and display never see bounce or metastable values.

Parameters:
- WIDTH, 4: bits per operand.
- STABLE_CYCLES, 1000000: consecutive cycles an input must hold before it is accepted (10 ms at 100 MHz); must be >= 2.
- CNT_BITS, 20: counter width; must satisfy 2^CNT_BITS > STABLE_CYCLES.
- LATCH_ON_LOAD, 1: 1 = A/B update only on a debounced button press; 0 = A/B follow debounced switches continuously.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  asynchronous, active-low reset (0 = reset).
- A_sw  in  WIDTH  raw switch operand A; asynchronous to clk.
- B_sw  in  WIDTH  raw switch operand B; asynchronous to clk.
- btn_load  in  1  raw pushbutton, active-high; asynchronous.
- A  out  WIDTH  debounced, registered operand A to the adder and display.
- B  out  WIDTH  debounced, registered operand B.
- load_pulse  out  1  one-cycle strobe per accepted button press.
- changed  out  1  one-cycle strobe on any cycle where A or B takes a new value.

Behaviour:
- Reset:
  - One clock domain. clr low asynchronously forces every flop to 0: synchronisers, candidates, counters, FSM (IDLE), A, B, load_pulse, changed.
  - Reset mid-count or mid-press discards all progress.
  - After release, the block behaves as if all inputs had been 0 (a held button needs a full STABLE_CYCLES press qualification).
- Synchronisation:
  - All 2*WIDTH+1 raw inputs pass a 2-flop synchroniser (reset 0) before any logic.
- Switch filter (one shared counter over the 2*WIDTH-bit vector):
  - sync != cand: cand <= sync, cnt <= 0.
  - else if cnt == STABLE_CYCLES-1: sw_stable <= cand; cnt holds (saturates, no wrap).
  - else: cnt <= cnt+1.
  - Any bit toggling restarts the whole vector's qualification. A toggle that reverts before the count completes never reaches sw_stable.
- Button FSM, using its own counter bcnt:
  - IDLE: on btn_s=1, go to PRESS_CHK with bcnt <= 0.
  - PRESS_CHK: btn_s=0 returns to IDLE. bcnt reaching STABLE_CYCLES-1 enters PRESSED, and load_pulse <= 1 for exactly that one following cycle.
  - PRESSED: btn_s=0 goes to RELEASE_CHK with bcnt <= 0. No further pulses while held.
  - RELEASE_CHK: btn_s=1 returns to PRESSED (no new pulse). bcnt reaching STABLE_CYCLES-1 goes to IDLE.
  - Exactly one load_pulse per press/release cycle, regardless of bounce.
- Operand register:
  - LATCH_ON_LOAD=1: {A,B} <= sw_stable on the same edge that asserts load_pulse. Otherwise hold.
  - LATCH_ON_LOAD=0: {A,B} <= sw_stable every cycle; load_pulse still generated.
  - changed <= 1 on the edge where the new {A,B} differs from the old; otherwise 0. A load with identical values gives load_pulse=1, changed=0.
- Latency, LATCH_ON_LOAD=0: a clean switch step reaches A/B on the (STABLE_CYCLES+3)th rising edge, counting the first edge that samples the new level.
- Latency, button: load_pulse asserts on the (STABLE_CYCLES+3)th edge after a clean press.
- Simultaneous events: a switch change and a button press in the same qualification window are independent. The load latches whatever sw_stable holds at the pulse edge, never an unqualified value.

Decomposition:
- Shared package: STABLE_CYCLES_DEFAULT, CNT_BITS_DEFAULT, and the button FSM state enum {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK} (2-bit encoding).
- One sub-module: sync_2ff (parameterised width, async active-low clr, reset value 0), instantiated once for the 2*WIDTH+1 raw inputs.
- Switch filter and button FSM stay inline.

Test Plan:
All cases use STABLE_CYCLES=4.
- Reset: clr=0 mid-run with A_sw=4'hF and btn held -> A=0, B=0, load_pulse=0, changed=0 immediately. After clr=1 with btn still held, exactly one load_pulse after 7 edges.
- Clean load, LATCH_ON_LOAD=1: A_sw=4'h9, B_sw=4'h7, wait 10 cycles, then press btn for 20 cycles -> A=9 and B=7 on the 7th edge after the press, with load_pulse=1 and changed=1 for exactly one cycle on that edge.
- Bounce rejection: btn toggles 1,0,1,0 every 2 cycles, then holds 1 -> one load_pulse only, 7 edges after the final rise. Release bouncing 0,1,0 -> no extra pulse.
- Switch glitch, LATCH_ON_LOAD=0: A_sw 4'h3 -> 4'hB for 3 cycles -> back to 4'h3 -> A stays 3, changed never asserts. A_sw 4'h3 -> 4'hB held -> A=B(hex) on edge 7, changed pulses once.
- Repeat load with unchanged switches: second press -> load_pulse=1, changed=0, A/B unchanged.
- Load during switch change: B_sw 4'h2 -> 4'h5 two cycles before load_pulse -> latched B=2. The next press latches B=5.

Source files
------------

// File: rtl/operand_debounce_pkg.sv
// Shared constants and button FSM encoding for the operand debounce front end.
package operand_debounce_pkg;

    localparam int unsigned WIDTH_DEFAULT         = 4;
    localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned CNT_BITS_DEFAULT      = 20;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

endpackage

// File: rtl/operand_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both stages clear to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/operand_debounce.sv
// Synchronises and debounces two switch operands and a load button, producing
// registered operands, a one-cycle load strobe and a value-change strobe.
module operand_debounce
    import operand_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEFAULT,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_BITS      = CNT_BITS_DEFAULT,
    parameter bit          LATCH_ON_LOAD = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] A_sw,
    input  logic [WIDTH-1:0] B_sw,
    input  logic             btn_load,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             load_pulse,
    output logic             changed
);

    localparam int unsigned VW = 2 * WIDTH;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [VW:0]   raw_vec;
    logic [VW:0]   sync_vec;
    logic [VW-1:0] sw_s;
    logic          btn_s;

    assign raw_vec = {btn_load, A_sw, B_sw};

    sync_2ff #(
        .WIDTH(VW + 1)
    ) u_sync (
        .clk(clk),
        .clr(clr),
        .d  (raw_vec),
        .q  (sync_vec)
    );

    assign sw_s  = sync_vec[VW-1:0];
    assign btn_s = sync_vec[VW];

    // Switch filter: one shared counter qualifies the whole operand vector.
    logic [VW-1:0]       cand;
    logic [VW-1:0]       cand_d;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_d;
    logic [VW-1:0]       sw_stable;
    logic [VW-1:0]       sw_stable_d;

    always_comb begin
        cand_d      = cand;
        cnt_d       = cnt;
        sw_stable_d = sw_stable;
        if (sw_s != cand) begin
            cand_d = sw_s;
            cnt_d  = '0;
        end else if (cnt == CNT_LAST) begin
            sw_stable_d = cand;
        end else begin
            cnt_d = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cand      <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else begin
            cand      <= cand_d;
            cnt       <= cnt_d;
            sw_stable <= sw_stable_d;
        end
    end

    // Button FSM: press and release each need a full qualification window.
    btn_state_t          state;
    btn_state_t          state_d;
    logic [CNT_BITS-1:0] bcnt;
    logic [CNT_BITS-1:0] bcnt_d;
    logic                load_pulse_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            bcnt       <= '0;
            load_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            bcnt       <= bcnt_d;
            load_pulse <= load_pulse_d;
        end
    end

    always_comb begin
        state_d      = state;
        bcnt_d       = bcnt;
        load_pulse_d = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_CHK;
                    bcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (bcnt == CNT_LAST) begin
                    state_d      = PRESSED;
                    load_pulse_d = 1'b1;
                end else begin
                    bcnt_d = bcnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_CHK;
                    bcnt_d  = '0;
                end
            end
            RELEASE_CHK: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (bcnt == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    bcnt_d = bcnt + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand register; the latched mode takes sw_stable as held before the strobe edge.
    logic [VW-1:0] ab_q;
    logic [VW-1:0] ab_d;
    logic          changed_d;

    always_comb begin
        ab_d = ab_q;
        if (LATCH_ON_LOAD) begin
            if (load_pulse_d) begin
                ab_d = sw_stable;
            end
        end else begin
            ab_d = sw_stable_d;
        end
        changed_d = (ab_d != ab_q);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ab_q    <= '0;
            changed <= 1'b0;
        end else begin
            ab_q    <= ab_d;
            changed <= changed_d;
        end
    end

    assign A = ab_q[VW-1:WIDTH];
    assign B = ab_q[WIDTH-1:0];

endmodule

// File: tb/tb_operand_debounce.sv
// Scoreboard bench for operand_debounce: a window-based model predicts strobes,
// a negedge monitor compares them; latched and follow-mode instances run side by side.
module tb_operand_debounce;

    localparam int unsigned SC = 4;
    localparam int unsigned CB = 3;
    localparam int unsigned HL = SC + 3;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] A_sw;
    logic [3:0] B_sw;
    logic       btn_load;
    logic [3:0] a1, b1, a0, b0;
    logic       lp1, ch1, lp0, ch0;

    always #5 clk = ~clk;

    operand_debounce #(.WIDTH(4), .STABLE_CYCLES(SC), .CNT_BITS(CB), .LATCH_ON_LOAD(1'b1)) dut1 (
        .clk(clk), .clr(clr), .A_sw(A_sw), .B_sw(B_sw), .btn_load(btn_load),
        .A(a1), .B(b1), .load_pulse(lp1), .changed(ch1)
    );

    operand_debounce #(.WIDTH(4), .STABLE_CYCLES(SC), .CNT_BITS(CB), .LATCH_ON_LOAD(1'b0)) dut0 (
        .clk(clk), .clr(clr), .A_sw(A_sw), .B_sw(B_sw), .btn_load(btn_load),
        .A(a0), .B(b0), .load_pulse(lp0), .changed(ch0)
    );

    typedef struct packed {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
        logic       lp;
        logic       ch;
    } ev_t;

    ev_t        q1[$];
    ev_t        q0[$];
    logic [8:0] hist[$];
    int         cyc;
    logic [7:0] m_stable, m_ab1, m_ab0;
    bit         m_lvl;
    int         checks = 0;
    int         errors = 0;
    int         lp1_cnt = 0;
    int         ch0_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(HL); i++) hist.push_back(9'd0);
        m_stable = '0;
        m_ab1    = '0;
        m_ab0    = '0;
        m_lvl    = 1'b0;
        q1.delete();
        q0.delete();
    endtask

    always @(negedge clr) model_reset();

    // Reference: a level is accepted once SC+1 consecutive raw samples, seen two edges late, agree.
    always @(posedge clk) begin
        logic [7:0] st_new;
        logic [7:0] nab;
        bit         sw_eq;
        bit         b_flip;
        bit         pulse;
        if (clr === 1'b1) begin
            cyc++;
            hist.push_back({btn_load, A_sw, B_sw});
            if (hist.size() > HL) void'(hist.pop_front());
            sw_eq  = 1'b1;
            b_flip = 1'b1;
            for (int i = 0; i <= int'(SC); i++) begin
                if (hist[i][7:0] != hist[0][7:0]) sw_eq = 1'b0;
                if (hist[i][8] == m_lvl) b_flip = 1'b0;
            end
            st_new = sw_eq ? hist[0][7:0] : m_stable;
            pulse  = 1'b0;
            if (b_flip) begin
                m_lvl = ~m_lvl;
                pulse = m_lvl;
            end
            nab = pulse ? m_stable : m_ab1;
            if (pulse || nab != m_ab1) q1.push_back('{cyc, nab[7:4], nab[3:0], pulse, nab != m_ab1});
            m_ab1 = nab;
            nab = st_new;
            if (pulse || nab != m_ab0) q0.push_back('{cyc, nab[7:4], nab[3:0], pulse, nab != m_ab0});
            m_ab0 = nab;
            m_stable = st_new;
        end
    end

    function automatic int qsize(input int k);
        return (k == 1) ? q1.size() : q0.size();
    endfunction

    function automatic ev_t qfront(input int k);
        return (k == 1) ? q1[0] : q0[0];
    endfunction

    task automatic qpop(input int k);
        if (k == 1) void'(q1.pop_front());
        else void'(q0.pop_front());
    endtask

    task automatic mon_one(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic lp, input logic ch, input logic [7:0] exp_ab);
        ev_t e;
        chk($sformatf("ab_level_%0d", k), {8'd0, a, b}, {8'd0, exp_ab});
        while (qsize(k) > 0 && qfront(k).cyc < cyc) begin
            e = qfront(k);
            chk($sformatf("strobe_missing_%0d_cyc%0d", k, e.cyc), 16'd0, 16'd1);
            qpop(k);
        end
        if (qsize(k) > 0 && qfront(k).cyc == cyc) begin
            e = qfront(k);
            qpop(k);
            chk($sformatf("strobe_%0d_cyc%0d", k, cyc), {6'd0, a, b, lp, ch}, {6'd0, e.a, e.b, e.lp, e.ch});
        end else begin
            chk($sformatf("no_strobe_%0d_cyc%0d", k, cyc), {14'd0, lp, ch}, 16'd0);
        end
    endtask

    always @(negedge clk) begin
        if (clr === 1'b1) begin
            mon_one(1, a1, b1, lp1, ch1, m_ab1);
            mon_one(0, a0, b0, lp0, ch0, m_ab0);
            lp1_cnt += int'(lp1);
            ch0_cnt += int'(ch0);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edges_then_sample(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_A1"}, {12'd0, a1}, 16'd0);
        chk({tag, "_B1"}, {12'd0, b1}, 16'd0);
        chk({tag, "_lp1"}, {15'd0, lp1}, 16'd0);
        chk({tag, "_ch1"}, {15'd0, ch1}, 16'd0);
        chk({tag, "_A0"}, {12'd0, a0}, 16'd0);
        chk({tag, "_B0"}, {12'd0, b0}, 16'd0);
        chk({tag, "_lp0"}, {15'd0, lp0}, 16'd0);
        chk({tag, "_ch0"}, {15'd0, ch0}, 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hold;
        cyc      = 0;
        clr      = 1'b1;
        A_sw     = 4'h0;
        B_sw     = 4'h0;
        btn_load = 1'b0;
        model_reset();
        #2 clr = 1'b0;
        #1 chk_all_zero("reset_init");
        wait_neg(3);
        clr = 1'b1;

        // Clean load in latched mode
        A_sw = 4'h9; B_sw = 4'h7;
        wait_neg(10);
        btn_load = 1'b1;
        edges_then_sample(7);
        chk("clean_lp", {15'd0, lp1}, 16'd1);
        chk("clean_ch", {15'd0, ch1}, 16'd1);
        chk("clean_AB", {8'd0, a1, b1}, 16'h0097);
        edges_then_sample(1);
        chk("clean_lp_one_cycle", {15'd0, lp1}, 16'd0);
        wait_neg(12);
        btn_load = 1'b0;
        wait_neg(12);

        // Repeat load, unchanged switches
        btn_load = 1'b1;
        edges_then_sample(7);
        chk("repeat_lp", {15'd0, lp1}, 16'd1);
        chk("repeat_ch", {15'd0, ch1}, 16'd0);
        chk("repeat_AB", {8'd0, a1, b1}, 16'h0097);
        wait_neg(10);
        btn_load = 1'b0;
        wait_neg(12);

        // Bounced press and release
        c = lp1_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_load = (i % 2 == 0);
            wait_neg(2);
        end
        btn_load = 1'b1;
        edges_then_sample(7);
        chk("bounce_lp", {15'd0, lp1}, 16'd1);
        wait_neg(10);
        btn_load = 1'b0; wait_neg(2);
        btn_load = 1'b1; wait_neg(2);
        btn_load = 1'b0; wait_neg(12);
        chk("bounce_pulse_count", 16'(lp1_cnt - c), 16'd1);

        // Switch change just before the load strobe
        B_sw = 4'h2;
        wait_neg(12);
        btn_load = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) B_sw = 4'h5;
        edges_then_sample(3);
        chk("midchange_lp", {15'd0, lp1}, 16'd1);
        chk("midchange_AB", {8'd0, a1, b1}, 16'h0092);
        wait_neg(10);
        btn_load = 1'b0;
        wait_neg(12);
        btn_load = 1'b1;
        edges_then_sample(7);
        chk("next_press_AB", {8'd0, a1, b1}, 16'h0095);
        chk("next_press_ch", {15'd0, ch1}, 16'd1);
        wait_neg(10);
        btn_load = 1'b0;
        wait_neg(12);

        // Glitch rejection in follow mode
        A_sw = 4'h3;
        wait_neg(12);
        c = ch0_cnt;
        A_sw = 4'hB; wait_neg(3);
        A_sw = 4'h3; wait_neg(12);
        chk("glitch_changed", 16'(ch0_cnt - c), 16'd0);
        chk("glitch_A", {12'd0, a0}, 16'h3);
        A_sw = 4'hB;
        edges_then_sample(7);
        chk("step_A", {12'd0, a0}, 16'hB);
        chk("step_ch", {15'd0, ch0}, 16'd1);
        wait_neg(10);
        chk("step_changed_count", 16'(ch0_cnt - c), 16'd1);

        // Reset mid-press, button held through release
        @(negedge clk);
        A_sw = 4'hF; btn_load = 1'b1;
        wait_neg(3);
        @(posedge clk);
        #2 clr = 1'b0;
        #1 chk_all_zero("reset_mid");
        wait_neg(2);
        clr = 1'b1;
        c = lp1_cnt;
        edges_then_sample(7);
        chk("reset_held_lp", {15'd0, lp1}, 16'd1);
        wait_neg(10);
        chk("reset_held_count", 16'(lp1_cnt - c), 16'd1);
        btn_load = 1'b0;
        wait_neg(12);

        // Random mix of switch steps and button bounce
        for (int s = 0; s < 250; s++) begin
            case ($urandom_range(0, 3))
                0: A_sw = 4'($urandom);
                1: B_sw = 4'($urandom);
                2: btn_load = ~btn_load;
                default: begin
                    A_sw = 4'($urandom);
                    btn_load = ~btn_load;
                end
            endcase
            hold = int'($urandom_range(1, 8));
            wait_neg(hold);
        end
        btn_load = 1'b0;
        wait_neg(20);
        chk("drain_q1", 16'(q1.size()), 16'd0);
        chk("drain_q0", 16'(q0.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
